hispi_lane_decoder: RTL and testbench
=====================================

# hispi_lane_decoder

Single-lane HiSPi Packetized-SP sync-code decoder downstream of the per-lane deserializer that consumes the `hispi_interface` serial lanes. It receives parallel lane words on the pixel clock. It strips the FFF/000/000/code sync sequences and emits pixel words with frame and line markers. It checks each line's length against a programmed value and reports protocol errors. One instance exists per lane; the lane-merger stage downstream consumes its outputs.

## Interface
- `PIXEL_SIZE`, 12, lane word width in bits (10 or 12).
- `COUNT_WIDTH`, 13, width of the pixel counter and the line-length register.
- `pclk` input 1: pixel clock; all logic on the rising edge.
- `pclk_reset_n` input 1: reset, synchronous, active-low.
- `cfg_enable` input 1: decoder enable. While 0, the FSM is held in IDLE and the pipeline is flushed.
- `cfg_line_length` input COUNT_WIDTH: expected pixels per line.
- `clr_status` input 1: clears the sticky error bits.
- `lane_data` input PIXEL_SIZE: deserialized lane word.
- `lane_valid` input 1: `lane_data` is valid this cycle.
- `pix_data` output PIXEL_SIZE: pixel word.
- `pix_valid` output 1: `pix_data` is valid.
- `sof`, `sol`, `eol`, `eof` output 1 each: single-cycle marker pulses.
- `line_pixel_count` output COUNT_WIDTH: pixel count of the last completed line.
- `line_length_error` output 1: sticky; a line ended with count ≠ `cfg_line_length`.
- `sync_error` output 1: sticky; illegal code or illegal sequence.

## Operation
- **Input pipeline.** A 3-stage shift register s1→s2→s3 advances only when `lane_valid` = 1.
- **Sync detection.** Sync is detected when `lane_valid` = 1 and s3 = all-ones, s2 = 0, s1 = 0. The incoming word is then the code word.
  - On detection, s1..s3 are discarded (all three are zeroed), so no sync word is ever emitted as a pixel.
  - The code word's bits [2:0] are decoded: 011 = SOF, 001 = SOL, 101 = EOL, 111 = EOF. Any other value sets `sync_error`.
- **Pixel emission.** When there is no detection and the FSM is in LINE, the old s3 is emitted as a pixel, but only if that s3 slot was filled by a word accepted in LINE. A per-stage valid bit tracks this.
- **FSM states:** IDLE, GAP (inside a frame, between lines), LINE.
  - SOF from any state: → LINE; pulse `sof` and `sol`; clear the pixel counter. SOF received in LINE also sets `sync_error`.
  - SOL in GAP: → LINE; pulse `sol`; clear the counter. SOL in LINE: `sync_error`, stay in LINE, clear the counter. SOL in IDLE: `sync_error`, stay in IDLE.
  - EOL in LINE: → GAP; pulse `eol`; latch the counter into `line_pixel_count`; set `line_length_error` if the count ≠ `cfg_line_length`. EOL in IDLE or GAP: `sync_error`, no state change.
  - EOF in GAP: → IDLE; pulse `eof`. EOF in LINE: pulse `eol` and `eof` in the same cycle, perform the length check, set `sync_error`, → IDLE. EOF in IDLE: `sync_error`.
  - An illegal code causes no state change.
- **Pixel counter.** Increments on each emitted pixel and saturates at 2^COUNT_WIDTH−1.
- **Sticky errors.** A set event has priority over `clr_status` in the same cycle.
- **Enable low.** `cfg_enable` = 0 forces IDLE, clears the stage valid bits, and suppresses all outputs except the sticky bits.

## Timing
- All outputs are registered.
- **Reset values:** `pix_data` 0, `pix_valid` 0, all markers 0, `line_pixel_count` 0, both errors 0, FSM IDLE, pipeline zeroed.
- **Reset mid-line:** returns to IDLE immediately. No `eol` is emitted, and the next line is decoded only after a new SOF.
- **Markers:** asserted the cycle after the code word is accepted.
- **Pixel latency:** a pixel accepted at valid-beat n appears on `pix_valid` the cycle after valid-beat n+3. The last pixel of a line is emitted the cycle after the second 000 of the EOL sequence, which is before `eol`.
- **Gaps:** `lane_valid` gaps stall the pipeline without loss. There is no backpressure, and throughput is 1 word/cycle.

## Structure
- Shared package `hispi_pkg`:
  - Sync code constants SOF/SOL/EOL/EOF.
  - FSM state enum `hispi_dec_state_t`.
  - Function `is_sync_prefix(s3, s2, s1)`, parameterized by PIXEL_SIZE.
- Sub-module `hispi_word_pipe`: the 3-stage valid-gated shift register with per-stage pixel-valid bits and a flush input.

## Test plan
- **Nominal line.** PIXEL_SIZE = 12, `cfg_line_length` = 4. Input SOF prefix, then pixels 0x101, 0x102, 0x103, 0x104, then EOL. Expect: `sof`+`sol`; 4 `pix_valid` beats with exactly those values in order; `eol`; `line_pixel_count` = 4; no errors.
- **Stalled input.** Same frame with `lane_valid` deasserted every other cycle. Expect identical pixel values and count, with markers delayed by the gaps only.
- **Length mismatch.** `cfg_line_length` = 5 with a 4-pixel line. Expect `line_length_error` = 1 after `eol`, staying set until `clr_status`. Assert `clr_status` together with a new mismatch: the bit stays 1.
- **Illegal sequences.** Code 0x000 after a prefix: expect `sync_error`, state unchanged. EOL in IDLE: expect `sync_error`. EOF in LINE after 2 pixels: expect `eol`+`eof` in the same cycle, `line_pixel_count` = 2, `sync_error`, then IDLE.
- **Reset and enable.** Assert `pclk_reset_n` = 0 after 2 pixels of a line: all outputs read 0 next cycle; subsequent SOL gives `sync_error` and no pixels. Repeat with `cfg_enable` = 0: no pixels, sticky bits retained.
- **Pixel look-alikes.** A pixel stream containing 0xFFF, 0x000, 0x123. Expect all three emitted as pixels, because the prefix is incomplete.

Source files
------------

// File: rtl/hispi_lane_decoder_pkg.sv
// Shared HiSPi decoder definitions: sync code values, decoder state encoding
// and the sync-prefix matcher used by every lane instance.
package hispi_pkg;

  localparam int HISPI_MAX_W = 12;

  localparam logic [2:0] SYNC_SOF = 3'b011;
  localparam logic [2:0] SYNC_SOL = 3'b001;
  localparam logic [2:0] SYNC_EOL = 3'b101;
  localparam logic [2:0] SYNC_EOF = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_LINE = 2'd2
  } hispi_dec_state_t;

  // Words are zero-extended to HISPI_MAX_W; only the low psize bits take part.
  function automatic logic is_sync_prefix(input logic [HISPI_MAX_W-1:0] s3,
                                          input logic [HISPI_MAX_W-1:0] s2,
                                          input logic [HISPI_MAX_W-1:0] s1,
                                          input int                     psize);
    logic [HISPI_MAX_W-1:0] mask;
    for (int i = 0; i < HISPI_MAX_W; i++) mask[i] = (i < psize);
    return ((s3 & mask) == mask) && ((s2 & mask) == '0) && ((s1 & mask) == '0);
  endfunction

endpackage

// File: rtl/hispi_lane_decoder_if.sv
// Deserialized lane word stream feeding one lane decoder.
interface hispi_lane_decoder_if #(
  parameter int PIXEL_SIZE = 12
) ();
  logic [PIXEL_SIZE-1:0] lane_data;
  logic                  lane_valid;

  modport master (output lane_data, output lane_valid);
  modport slave  (input  lane_data, input  lane_valid);
endinterface

// File: rtl/hispi_word_pipe.sv
// Three-deep lane word history, advanced only on valid beats, with a pixel
// flag per stage marking words that were accepted inside a line.
module hispi_word_pipe
  import hispi_pkg::*;
#(
  parameter int PIXEL_SIZE = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  adv_i,
  input  logic                  clear_i,
  input  logic [PIXEL_SIZE-1:0] data_i,
  input  logic                  pv_i,
  output logic [PIXEL_SIZE-1:0] s1_o,
  output logic [PIXEL_SIZE-1:0] s2_o,
  output logic [PIXEL_SIZE-1:0] s3_o,
  output logic                  v3_o
);

  logic [PIXEL_SIZE-1:0] s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic                  v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;

  always_comb begin
    s1_d = s1_q; s2_d = s2_q; s3_d = s3_q;
    v1_d = v1_q; v2_d = v2_q; v3_d = v3_q;
    // A detected sync discards the whole prefix so it never leaks out as pixels.
    if (flush_i || (adv_i && clear_i)) begin
      s1_d = '0; s2_d = '0; s3_d = '0;
      v1_d = 1'b0; v2_d = 1'b0; v3_d = 1'b0;
    end else if (adv_i) begin
      s1_d = data_i; s2_d = s1_q; s3_d = s2_q;
      v1_d = pv_i;   v2_d = v1_q; v3_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0; s2_q <= '0; s3_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
    end else begin
      s1_q <= s1_d; s2_q <= s2_d; s3_q <= s3_d;
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
    end
  end

  assign s1_o = s1_q;
  assign s2_o = s2_q;
  assign s3_o = s3_q;
  assign v3_o = v3_q;

endmodule

// File: rtl/hispi_lane_decoder.sv
// Single-lane HiSPi Packetized-SP decoder: strips sync sequences, emits pixels
// with frame/line markers, checks line length and flags protocol errors.
module hispi_lane_decoder
  import hispi_pkg::*;
#(
  parameter int PIXEL_SIZE  = 12,
  parameter int COUNT_WIDTH = 13
) (
  input  logic                   pclk,
  input  logic                   pclk_reset_n,
  input  logic                   cfg_enable,
  input  logic [COUNT_WIDTH-1:0] cfg_line_length,
  input  logic                   clr_status,
  hispi_lane_decoder_if.slave    lane,
  output logic [PIXEL_SIZE-1:0]  pix_data,
  output logic                   pix_valid,
  output logic                   sof,
  output logic                   sol,
  output logic                   eol,
  output logic                   eof,
  output logic [COUNT_WIDTH-1:0] line_pixel_count,
  output logic                   line_length_error,
  output logic                   sync_error
);

  hispi_dec_state_t      state_q, state_d;
  logic [PIXEL_SIZE-1:0] s1, s2, s3, pix_data_q, pix_data_d;
  logic                  v3, accept, detect, emit;
  logic                  pix_valid_q, pix_valid_d, sof_q, sof_d, sol_q, sol_d;
  logic                  eol_q, eol_d, eof_q, eof_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, lpc_q, lpc_d;
  logic                  len_err_q, len_err_d, sync_err_q, sync_err_d;
  logic [2:0]            code;

  hispi_word_pipe #(.PIXEL_SIZE(PIXEL_SIZE)) u_pipe (
    .clk     (pclk),
    .rst_n   (pclk_reset_n),
    .flush_i (~cfg_enable),
    .adv_i   (lane.lane_valid),
    .clear_i (detect),
    .data_i  (lane.lane_data),
    .pv_i    (state_q == ST_LINE),
    .s1_o    (s1),
    .s2_o    (s2),
    .s3_o    (s3),
    .v3_o    (v3)
  );

  assign accept = cfg_enable & lane.lane_valid;
  assign detect = accept & is_sync_prefix(HISPI_MAX_W'(s3), HISPI_MAX_W'(s2),
                                          HISPI_MAX_W'(s1), PIXEL_SIZE);
  assign emit   = accept & ~detect & (state_q == ST_LINE) & v3;
  assign code   = lane.lane_data[2:0];

  always_comb begin
    state_d     = state_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    sof_d = 1'b0; sol_d = 1'b0; eol_d = 1'b0; eof_d = 1'b0;
    cnt_d       = cnt_q;
    lpc_d       = lpc_q;
    len_err_d   = len_err_q & ~clr_status;
    sync_err_d  = sync_err_q & ~clr_status;
    if (!cfg_enable) begin
      state_d    = ST_IDLE;
      pix_data_d = '0;
    end else if (detect) begin
      case (code)
        SYNC_SOF: begin
          if (state_q == ST_LINE) sync_err_d = 1'b1;
          state_d = ST_LINE; sof_d = 1'b1; sol_d = 1'b1; cnt_d = '0;
        end
        SYNC_SOL: begin
          case (state_q)
            ST_GAP:  begin state_d = ST_LINE; sol_d = 1'b1; cnt_d = '0; end
            ST_LINE: begin sync_err_d = 1'b1; cnt_d = '0; end
            default: sync_err_d = 1'b1;
          endcase
        end
        SYNC_EOL: begin
          if (state_q == ST_LINE) begin
            state_d = ST_GAP; eol_d = 1'b1; lpc_d = cnt_q;
            if (cnt_q != cfg_line_length) len_err_d = 1'b1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        SYNC_EOF: begin
          case (state_q)
            ST_GAP:  begin state_d = ST_IDLE; eof_d = 1'b1; end
            // A frame closed mid-line still reports the truncated line.
            ST_LINE: begin
              state_d = ST_IDLE; eol_d = 1'b1; eof_d = 1'b1; lpc_d = cnt_q;
              sync_err_d = 1'b1;
              if (cnt_q != cfg_line_length) len_err_d = 1'b1;
            end
            default: sync_err_d = 1'b1;
          endcase
        end
        default: sync_err_d = 1'b1;
      endcase
    end else if (emit) begin
      pix_valid_d = 1'b1;
      pix_data_d  = s3;
      if (cnt_q != {COUNT_WIDTH{1'b1}}) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (!pclk_reset_n) begin
      state_q     <= ST_IDLE;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      sof_q <= 1'b0; sol_q <= 1'b0; eol_q <= 1'b0; eof_q <= 1'b0;
      cnt_q       <= '0;
      lpc_q       <= '0;
      len_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      sof_q <= sof_d; sol_q <= sol_d; eol_q <= eol_d; eof_q <= eof_d;
      cnt_q       <= cnt_d;
      lpc_q       <= lpc_d;
      len_err_q   <= len_err_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign pix_data          = pix_data_q;
  assign pix_valid         = pix_valid_q;
  assign sof               = sof_q;
  assign sol               = sol_q;
  assign eol               = eol_q;
  assign eof               = eof_q;
  assign line_pixel_count  = lpc_q;
  assign line_length_error = len_err_q;
  assign sync_error        = sync_err_q;

endmodule

// File: tb/tb_hispi_lane_decoder.sv
// Directed bench for hispi_lane_decoder: nominal, stalled, error and reset scenarios.
module tb_hispi_lane_decoder;

  localparam int PS = 12;
  localparam int CW = 13;
  localparam logic [PS-1:0] W_SOF = 12'h003;
  localparam logic [PS-1:0] W_SOL = 12'h001;
  localparam logic [PS-1:0] W_EOL = 12'h005;
  localparam logic [PS-1:0] W_EOF = 12'h007;

  logic          pclk = 1'b0;
  logic          pclk_reset_n, cfg_enable, clr_status;
  logic [CW-1:0] cfg_line_length;
  logic [PS-1:0] pix_data;
  logic          pix_valid, sof, sol, eol, eof;
  logic [CW-1:0] line_pixel_count;
  logic          line_length_error, sync_error;

  hispi_lane_decoder_if #(.PIXEL_SIZE(PS)) lane_if ();

  hispi_lane_decoder #(.PIXEL_SIZE(PS), .COUNT_WIDTH(CW)) dut (
    .pclk              (pclk),
    .pclk_reset_n      (pclk_reset_n),
    .cfg_enable        (cfg_enable),
    .cfg_line_length   (cfg_line_length),
    .clr_status        (clr_status),
    .lane              (lane_if),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .sof               (sof),
    .sol               (sol),
    .eol               (eol),
    .eof               (eof),
    .line_pixel_count  (line_pixel_count),
    .line_length_error (line_length_error),
    .sync_error        (sync_error)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  // Output monitor, sampled on the falling edge.
  logic [PS-1:0] pix_q[$];
  int cyc = 0, n_sof = 0, n_sol = 0, n_eol = 0, n_eof = 0, n_both = 0;
  int last_pix_cyc = 0, eol_cyc = 0;
  int b_pix, b_sof, b_sol, b_eol, b_eof, b_both;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (pix_valid) begin
      pix_q.push_back(pix_data);
      last_pix_cyc <= cyc;
    end
    if (eol) eol_cyc <= cyc;
    n_sof  <= n_sof + int'(sof);
    n_sol  <= n_sol + int'(sol);
    n_eol  <= n_eol + int'(eol);
    n_eof  <= n_eof + int'(eof);
    n_both <= n_both + int'(eol & eof);
  end

  task automatic mark();
    b_pix = pix_q.size(); b_sof = n_sof; b_sol = n_sol;
    b_eol = n_eol; b_eof = n_eof; b_both = n_both;
  endtask

  task automatic drive(input logic [PS-1:0] w, input logic v);
    lane_if.lane_data  = w;
    lane_if.lane_valid = v;
    @(posedge pclk);
    #1;
  endtask

  task automatic word(input logic [PS-1:0] w, input logic stall);
    if (stall) drive('0, 1'b0);
    drive(w, 1'b1);
  endtask

  task automatic sync_seq(input logic [PS-1:0] c, input logic stall);
    word(12'hFFF, stall); word(12'h000, stall); word(12'h000, stall); word(c, stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  task automatic clear_sticky();
    clr_status = 1'b1; drive('0, 1'b0); clr_status = 1'b0;
  endtask

  function automatic logic [PS-1:0] pix_at(input int idx);
    return (idx < pix_q.size()) ? pix_q[idx] : 'x;
  endfunction

  task automatic test_reset();
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    tests++; if (pix_data !== '0) begin fails++; $display("FAIL reset_pix_data: got %h want 000", pix_data); end
    tests++; if ({sof, sol, eol, eof} !== 4'b0) begin fails++; $display("FAIL reset_markers: got %b want 0000", {sof, sol, eol, eof}); end
    tests++; if (line_pixel_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", line_pixel_count); end
    tests++; if ({line_length_error, sync_error} !== 2'b0) begin fails++; $display("FAIL reset_errors: got %b want 00", {line_length_error, sync_error}); end
  endtask

  task automatic test_line(input logic stall);
    logic [PS-1:0] exp_pix [4];
    exp_pix = '{12'h101, 12'h102, 12'h103, 12'h104};
    cfg_line_length = 13'd4;
    mark();
    sync_seq(W_SOF, stall);
    for (int i = 0; i < 4; i++) word(exp_pix[i], stall);
    sync_seq(W_EOL, stall);
    idle(3);
    tests++; if ((n_sof - b_sof) !== 1 || (n_sol - b_sol) !== 1) begin fails++; $display("FAIL line_sof_sol stall=%0b: got %0d/%0d want 1/1", stall, n_sof - b_sof, n_sol - b_sol); end
    tests++; if ((pix_q.size() - b_pix) !== 4) begin fails++; $display("FAIL line_pix_count stall=%0b: got %0d want 4", stall, pix_q.size() - b_pix); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (pix_at(b_pix + i) !== exp_pix[i]) begin fails++; $display("FAIL line_pix%0d stall=%0b: got %h want %h", i, stall, pix_at(b_pix + i), exp_pix[i]); end
    end
    tests++; if ((n_eol - b_eol) !== 1) begin fails++; $display("FAIL line_eol stall=%0b: got %0d want 1", stall, n_eol - b_eol); end
    tests++; if (last_pix_cyc >= eol_cyc) begin fails++; $display("FAIL line_eol_order stall=%0b: last pixel cycle %0d, eol cycle %0d", stall, last_pix_cyc, eol_cyc); end
    tests++; if (line_pixel_count !== 13'd4) begin fails++; $display("FAIL line_length stall=%0b: got %0d want 4", stall, line_pixel_count); end
    tests++; if ({line_length_error, sync_error} !== 2'b00) begin fails++; $display("FAIL line_errors stall=%0b: got %b want 00", stall, {line_length_error, sync_error}); end
    sync_seq(W_EOF, stall);
    idle(2);
    tests++; if ((n_eof - b_eof) !== 1 || (n_both - b_both) !== 0) begin fails++; $display("FAIL line_eof stall=%0b: got eof %0d both %0d want 1/0", stall, n_eof - b_eof, n_both - b_both); end
    tests++; if (sync_error !== 1'b0) begin fails++; $display("FAIL line_eof_sync stall=%0b: got %b want 0", stall, sync_error); end
  endtask

  task automatic test_length_mismatch();
    cfg_line_length = 13'd5;
    sync_seq(W_SOF, 1'b0);
    for (int i = 0; i < 4; i++) word(12'h200 + 12'(i), 1'b0);
    sync_seq(W_EOL, 1'b0);
    idle(2);
    tests++; if (line_length_error !== 1'b1) begin fails++; $display("FAIL len_err_set: got %b want 1", line_length_error); end
    tests++; if (line_pixel_count !== 13'd4) begin fails++; $display("FAIL len_count: got %0d want 4", line_pixel_count); end
    idle(5);
    tests++; if (line_length_error !== 1'b1) begin fails++; $display("FAIL len_err_sticky: got %b want 1", line_length_error); end
    sync_seq(W_SOL, 1'b0);
    for (int i = 0; i < 4; i++) word(12'h210 + 12'(i), 1'b0);
    word(12'hFFF, 1'b0); word(12'h000, 1'b0); word(12'h000, 1'b0);
    clr_status = 1'b1;
    drive(W_EOL, 1'b1);
    clr_status = 1'b0;
    tests++; if (line_length_error !== 1'b1) begin fails++; $display("FAIL len_set_over_clr: got %b want 1", line_length_error); end
    clear_sticky();
    tests++; if (line_length_error !== 1'b0) begin fails++; $display("FAIL len_clr: got %b want 0", line_length_error); end
    sync_seq(W_EOF, 1'b0);
    idle(2);
  endtask

  task automatic test_illegal();
    cfg_line_length = 13'd2;
    clear_sticky();
    mark();
    sync_seq(W_SOF, 1'b0);
    word(12'h011, 1'b0); word(12'h012, 1'b0);
    sync_seq(W_EOL, 1'b0);
    idle(2);
    sync_seq(12'h000, 1'b0);
    idle(1);
    tests++; if (sync_error !== 1'b1) begin fails++; $display("FAIL illegal_code: got %b want 1", sync_error); end
    clear_sticky();
    sync_seq(W_SOL, 1'b0);
    tests++; if (sync_error !== 1'b0) begin fails++; $display("FAIL illegal_state_kept: got sync_error %b want 0", sync_error); end
    word(12'h021, 1'b0); word(12'h022, 1'b0);
    sync_seq(W_EOF, 1'b0);
    idle(2);
    tests++; if ((n_both - b_both) !== 1) begin fails++; $display("FAIL eof_in_line_markers: got %0d want 1", n_both - b_both); end
    tests++; if (line_pixel_count !== 13'd2) begin fails++; $display("FAIL eof_in_line_count: got %0d want 2", line_pixel_count); end
    tests++; if (sync_error !== 1'b1) begin fails++; $display("FAIL eof_in_line_sync: got %b want 1", sync_error); end
    tests++; if ((pix_q.size() - b_pix) !== 4 || pix_at(b_pix + 3) !== 12'h022) begin fails++; $display("FAIL eof_in_line_pixels: got %0d last %h want 4 last 022", pix_q.size() - b_pix, pix_at(b_pix + 3)); end
    clear_sticky();
    mark();
    sync_seq(W_EOL, 1'b0);
    idle(2);
    tests++; if (sync_error !== 1'b1 || (n_eol - b_eol) !== 0) begin fails++; $display("FAIL eol_in_idle: got sync %b eol %0d want 1/0", sync_error, n_eol - b_eol); end
  endtask

  task automatic test_reset_mid();
    sync_seq(W_SOF, 1'b0);
    word(12'h031, 1'b0); word(12'h032, 1'b0);
    pclk_reset_n = 1'b0;
    drive('0, 1'b0);
    tests++; if ({pix_valid, sof, sol, eol, eof} !== 5'b0 || pix_data !== '0) begin fails++; $display("FAIL midreset_outputs: got %b data %h want 0", {pix_valid, sof, sol, eol, eof}, pix_data); end
    tests++; if (line_pixel_count !== '0 || {line_length_error, sync_error} !== 2'b0) begin fails++; $display("FAIL midreset_status: got %0d %b want 0 00", line_pixel_count, {line_length_error, sync_error}); end
    pclk_reset_n = 1'b1;
    mark();
    sync_seq(W_SOL, 1'b0);
    idle(1);
    tests++; if (sync_error !== 1'b1) begin fails++; $display("FAIL midreset_sol_sync: got %b want 1", sync_error); end
    for (int i = 0; i < 4; i++) word(12'h041 + 12'(i), 1'b0);
    idle(4);
    tests++; if ((pix_q.size() - b_pix) !== 0 || (n_sol - b_sol) !== 0 || (n_eol - b_eol) !== 0) begin fails++; $display("FAIL midreset_no_pixels: got pix %0d sol %0d eol %0d want 0", pix_q.size() - b_pix, n_sol - b_sol, n_eol - b_eol); end
  endtask

  task automatic test_enable();
    mark();
    sync_seq(W_SOF, 1'b0);
    cfg_enable = 1'b0;
    for (int i = 0; i < 4; i++) word(12'h051 + 12'(i), 1'b0);
    sync_seq(W_EOL, 1'b0);
    idle(3);
    tests++; if ((pix_q.size() - b_pix) !== 0 || (n_eol - b_eol) !== 0) begin fails++; $display("FAIL disable_no_output: got pix %0d eol %0d want 0", pix_q.size() - b_pix, n_eol - b_eol); end
    tests++; if (sync_error !== 1'b1) begin fails++; $display("FAIL disable_sticky: got %b want 1", sync_error); end
    cfg_enable = 1'b1;
    idle(1);
  endtask

  task automatic test_lookalike();
    logic [PS-1:0] exp_pix [5];
    exp_pix = '{12'h100, 12'hFFF, 12'h000, 12'h123, 12'h200};
    clear_sticky();
    cfg_line_length = 13'd5;
    mark();
    sync_seq(W_SOF, 1'b0);
    for (int i = 0; i < 5; i++) word(exp_pix[i], 1'b0);
    sync_seq(W_EOL, 1'b0);
    idle(2);
    tests++; if ((pix_q.size() - b_pix) !== 5) begin fails++; $display("FAIL lookalike_count: got %0d want 5", pix_q.size() - b_pix); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (pix_at(b_pix + i) !== exp_pix[i]) begin fails++; $display("FAIL lookalike_pix%0d: got %h want %h", i, pix_at(b_pix + i), exp_pix[i]); end
    end
    tests++; if (line_pixel_count !== 13'd5 || {line_length_error, sync_error} !== 2'b00) begin fails++; $display("FAIL lookalike_status: got %0d %b want 5 00", line_pixel_count, {line_length_error, sync_error}); end
    sync_seq(W_EOF, 1'b0);
    idle(2);
  endtask

  initial begin
    pclk_reset_n       = 1'b0;
    cfg_enable         = 1'b1;
    cfg_line_length    = 13'd4;
    clr_status         = 1'b0;
    lane_if.lane_data  = '0;
    lane_if.lane_valid = 1'b0;
    idle(3);
    pclk_reset_n = 1'b1;
    idle(1);
    test_reset();
    test_line(1'b0);
    test_line(1'b1);
    test_length_mismatch();
    test_illegal();
    test_reset_mid();
    test_enable();
    test_lookalike();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
